// File: rtl/pll_seq_pkg.sv
// -----------------------------------------------------------------------------
// pll_seq_pkg
//   Shared types and constants for the PLL reset/lock sequencer.
//   - pll_seq_state_t : sequencer state encoding
//   - DEF_*           : default timing parameters for a 50 MHz reference
//   - cnt_width()     : width of a counter that must hold the value 'limit'
// -----------------------------------------------------------------------------
package pll_seq_pkg;

   typedef enum logic [2:0] {
      ST_HOLD_RST  = 3'd0,
      ST_WAIT_LOCK = 3'd1,
      ST_STABLE    = 3'd2,
      ST_READY     = 3'd3,
      ST_FAULT     = 3'd4
   } pll_seq_state_t;

   localparam int DEF_RST_HOLD_CYCLES     = 50;     // 1 us at 50 MHz
   localparam int DEF_LOCK_STABLE_CYCLES  = 1024;
   localparam int DEF_LOCK_TIMEOUT_CYCLES = 50000;  // 1 ms at 50 MHz
   localparam int DEF_MAX_RETRIES         = 7;

   localparam int RETRY_PORT_W = 4;
   localparam int LOST_CNT_W   = 8;

   // Bits needed to represent every value 0..limit.
   function automatic int cnt_width(input int limit);
      return $clog2(limit + 1);
   endfunction

endpackage : pll_seq_pkg

// File: rtl/sync_2ff.sv
// -----------------------------------------------------------------------------
// sync_2ff
//   Two-flop synchroniser for a single asynchronous level signal.
//   Ports:
//     refclk  in  destination clock
//     rst_n   in  asynchronous active-low reset (both flops clear to 0)
//     d       in  asynchronous input
//     q       out synchronised output, two refclk edges of latency
// -----------------------------------------------------------------------------
module sync_2ff (
   input  logic refclk,
   input  logic rst_n,
   input  logic d,
   output logic q
);

   logic meta_q;
   logic sync_q;

   // NOTE: sequential state uses non-blocking assignments so every flop samples
   // the pre-edge value of its source; blocking here would collapse the chain
   // into a single flop.
   always_ff @(posedge refclk or negedge rst_n) begin
      if (!rst_n) begin
         meta_q <= 1'b0;
         sync_q <= 1'b0;
      end else begin
         meta_q <= d;
         sync_q <= meta_q;
      end
   end

   assign q = sync_q;

endmodule : sync_2ff

// File: rtl/pll_lock_sequencer.sv
// -----------------------------------------------------------------------------
// pll_lock_sequencer
//   Holds the board PLL in reset after power-up, waits for a debounced lock,
//   then flags the clock as usable. Re-sequences the PLL on loss of lock, on a
//   lock timeout (bounded number of retries, then FAULT) or on software request.
//   Ports:
//     refclk        in   free-running 50 MHz reference clock
//     rst_n         in   asynchronous active-low reset
//     pll_locked    in   PLL lock indicator, asynchronous to refclk
//     relock_req    in   single-cycle request to restart the sequence
//     pll_rst       out  active-high PLL reset (HOLD_RST and FAULT)
//     clk_ready     out  high only in READY
//     fault         out  high only in FAULT
//     retry_cnt     out  timeout retries in the current attempt series
//     lock_lost_cnt out  READY lock-loss events, saturating at 255
//   All outputs are registered; none has a combinational path from an input.
// -----------------------------------------------------------------------------
module pll_lock_sequencer
   import pll_seq_pkg::*;
#(
   parameter int RST_HOLD_CYCLES     = DEF_RST_HOLD_CYCLES,
   parameter int LOCK_STABLE_CYCLES  = DEF_LOCK_STABLE_CYCLES,
   parameter int LOCK_TIMEOUT_CYCLES = DEF_LOCK_TIMEOUT_CYCLES,
   parameter int MAX_RETRIES         = DEF_MAX_RETRIES
) (
   input  logic       refclk,
   input  logic       rst_n,
   input  logic       pll_locked,
   input  logic       relock_req,
   output logic       pll_rst,
   output logic       clk_ready,
   output logic       fault,
   output logic [3:0] retry_cnt,
   output logic [7:0] lock_lost_cnt
);

   localparam int HOLD_W  = cnt_width(RST_HOLD_CYCLES);
   localparam int STAB_W  = cnt_width(LOCK_STABLE_CYCLES);
   localparam int TMO_W   = cnt_width(LOCK_TIMEOUT_CYCLES);
   localparam int RETRY_W = cnt_width(MAX_RETRIES);

   // Each counter starts at 0 on state entry, so the last counted cycle is
   // limit-1; comparing for equality there gives exactly 'limit' cycles.
   localparam logic [HOLD_W-1:0]  HOLD_LAST = HOLD_W'(RST_HOLD_CYCLES - 1);
   localparam logic [STAB_W-1:0]  STAB_LAST = STAB_W'(LOCK_STABLE_CYCLES - 1);
   localparam logic [TMO_W-1:0]   TMO_LAST  = TMO_W'(LOCK_TIMEOUT_CYCLES - 1);
   localparam logic [RETRY_W-1:0] RETRY_MAX = RETRY_W'(MAX_RETRIES);
   localparam logic [LOST_CNT_W-1:0] LOST_SAT = '1;

   logic locked_s;

   pll_seq_state_t          state_q,     state_d;
   logic [HOLD_W-1:0]       hold_cnt_q,  hold_cnt_d;
   logic [STAB_W-1:0]       stab_cnt_q,  stab_cnt_d;
   logic [TMO_W-1:0]        tmo_cnt_q,   tmo_cnt_d;
   logic [RETRY_W-1:0]      retry_cnt_q, retry_cnt_d;
   logic [LOST_CNT_W-1:0]   lost_cnt_q,  lost_cnt_d;
   logic                    pll_rst_q,   pll_rst_d;
   logic                    clk_ready_q, clk_ready_d;
   logic                    fault_q,     fault_d;
   logic                    tmo_hit;

   sync_2ff u_lock_sync (
      .refclk (refclk),
      .rst_n  (rst_n),
      .d      (pll_locked),
      .q      (locked_s)
   );

   // -------------------------------------------------------------------------
   // Next-state and output logic
   // -------------------------------------------------------------------------
   always_comb begin
      // NOTE: every variable gets a default before any branch so no path can
      // leave it unassigned, which would otherwise infer a latch.
      state_d     = state_q;
      hold_cnt_d  = hold_cnt_q;
      stab_cnt_d  = stab_cnt_q;
      tmo_cnt_d   = tmo_cnt_q;
      retry_cnt_d = retry_cnt_q;
      lost_cnt_d  = lost_cnt_q;
      tmo_hit     = (tmo_cnt_q == TMO_LAST);

      if (relock_req) begin
         // Software restart beats everything and does not count as a lock loss.
         state_d     = ST_HOLD_RST;
         hold_cnt_d  = '0;
         retry_cnt_d = '0;
      end else begin
         unique case (state_q)
            ST_HOLD_RST: begin
               if (hold_cnt_q == HOLD_LAST) begin
                  state_d   = ST_WAIT_LOCK;
                  tmo_cnt_d = '0;
               end else begin
                  hold_cnt_d = hold_cnt_q + 1'b1;
               end
            end

            ST_WAIT_LOCK, ST_STABLE: begin
               if (tmo_hit) begin
                  if (retry_cnt_q == RETRY_MAX) begin
                     state_d = ST_FAULT;
                  end else begin
                     retry_cnt_d = retry_cnt_q + 1'b1;
                     state_d     = ST_HOLD_RST;
                     hold_cnt_d  = '0;
                  end
               end else begin
                  // The timeout window spans both states; a lock glitch in
                  // STABLE must not buy the PLL extra time.
                  tmo_cnt_d = tmo_cnt_q + 1'b1;
                  if (state_q == ST_WAIT_LOCK) begin
                     if (locked_s) begin
                        state_d    = ST_STABLE;
                        stab_cnt_d = '0;
                     end
                  end else if (!locked_s) begin
                     state_d = ST_WAIT_LOCK;
                  end else if (stab_cnt_q == STAB_LAST) begin
                     state_d = ST_READY;
                  end else begin
                     stab_cnt_d = stab_cnt_q + 1'b1;
                  end
               end
            end

            ST_READY: begin
               if (!locked_s) begin
                  if (lost_cnt_q != LOST_SAT) begin
                     lost_cnt_d = lost_cnt_q + 1'b1;
                  end
                  retry_cnt_d = '0;
                  state_d     = ST_HOLD_RST;
                  hold_cnt_d  = '0;
               end
            end

            ST_FAULT: begin
               // Parked with the PLL in reset until software asks again.
            end

            default: begin
               state_d    = ST_HOLD_RST;
               hold_cnt_d = '0;
            end
         endcase
      end

      // Outputs are decoded from the next state so they flip on the same edge
      // as the state register.
      pll_rst_d   = (state_d == ST_HOLD_RST) || (state_d == ST_FAULT);
      clk_ready_d = (state_d == ST_READY);
      fault_d     = (state_d == ST_FAULT);
   end

   // -------------------------------------------------------------------------
   // State and counter registers
   // -------------------------------------------------------------------------
   always_ff @(posedge refclk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= ST_HOLD_RST;
         hold_cnt_q  <= '0;
         stab_cnt_q  <= '0;
         tmo_cnt_q   <= '0;
         retry_cnt_q <= '0;
         lost_cnt_q  <= '0;
         pll_rst_q   <= 1'b1;
         clk_ready_q <= 1'b0;
         fault_q     <= 1'b0;
      end else begin
         state_q     <= state_d;
         hold_cnt_q  <= hold_cnt_d;
         stab_cnt_q  <= stab_cnt_d;
         tmo_cnt_q   <= tmo_cnt_d;
         retry_cnt_q <= retry_cnt_d;
         lost_cnt_q  <= lost_cnt_d;
         pll_rst_q   <= pll_rst_d;
         clk_ready_q <= clk_ready_d;
         fault_q     <= fault_d;
      end
   end

   assign pll_rst       = pll_rst_q;
   assign clk_ready     = clk_ready_q;
   assign fault         = fault_q;
   assign retry_cnt     = RETRY_PORT_W'(retry_cnt_q);
   assign lock_lost_cnt = lost_cnt_q;

endmodule : pll_lock_sequencer

// File: tb/tb_pll_lock_sequencer.sv
// -----------------------------------------------------------------------------
// tb_pll_lock_sequencer
//   Directed scenarios plus a randomized phase. A behavioural model, counting
//   elapsed cycles per phase, predicts every output; a compare process checks
//   the DUT against it on each falling edge. Literal edge counts pin the model.
// -----------------------------------------------------------------------------
module tb_pll_lock_sequencer;

   localparam int HOLD    = 4;
   localparam int STAB    = 8;
   localparam int TMO     = 32;
   localparam int RETRIES = 2;

   localparam int W_PLL_RST = 0;
   localparam int W_READY   = 1;
   localparam int W_FAULT   = 2;
   localparam int W_RETRY   = 3;
   localparam int W_LOST    = 4;

   logic       refclk     = 1'b0;
   logic       rst_n      = 1'b0;
   logic       pll_locked = 1'b0;
   logic       relock_req = 1'b0;
   logic       pll_rst;
   logic       clk_ready;
   logic       fault;
   logic [3:0] retry_cnt;
   logic [7:0] lock_lost_cnt;

   int total = 0;
   int bad   = 0;

   pll_lock_sequencer #(
      .RST_HOLD_CYCLES     (HOLD),
      .LOCK_STABLE_CYCLES  (STAB),
      .LOCK_TIMEOUT_CYCLES (TMO),
      .MAX_RETRIES         (RETRIES)
   ) dut (
      .refclk        (refclk),
      .rst_n         (rst_n),
      .pll_locked    (pll_locked),
      .relock_req    (relock_req),
      .pll_rst       (pll_rst),
      .clk_ready     (clk_ready),
      .fault         (fault),
      .retry_cnt     (retry_cnt),
      .lock_lost_cnt (lock_lost_cnt)
   );

   always #10 refclk = ~refclk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
      end
   endtask

   // ---------------------------------------------------------------------------
   // Behavioural model: phase plus elapsed-cycle counts, lock seen 2 edges late
   // ---------------------------------------------------------------------------
   localparam int P_HOLD = 0, P_WAIT = 1, P_STABLE = 2, P_READY = 3, P_FAULT = 4;

   int   m_phase, m_hold_elapsed, m_since_release, m_lock_run, m_retries, m_losses;
   logic m_s0, m_s1;

   task automatic model_reset();
      m_phase = P_HOLD;  m_hold_elapsed = 0; m_since_release = 0;
      m_lock_run = 0;    m_retries = 0;      m_losses = 0;
      m_s0 = 1'b0;       m_s1 = 1'b0;
   endtask

   task automatic model_step(input logic relock, input logic lk);
      logic ls;
      ls   = m_s1;
      m_s1 = m_s0;
      m_s0 = lk;
      if (relock) begin
         m_phase = P_HOLD; m_hold_elapsed = 0; m_retries = 0;
      end else begin
         case (m_phase)
            P_HOLD: begin
               m_hold_elapsed++;
               if (m_hold_elapsed == HOLD) begin
                  m_phase = P_WAIT; m_since_release = 0;
               end
            end
            P_WAIT, P_STABLE: begin
               m_since_release++;
               if (m_since_release == TMO) begin
                  if (m_retries == RETRIES) m_phase = P_FAULT;
                  else begin
                     m_retries++; m_phase = P_HOLD; m_hold_elapsed = 0;
                  end
               end else if (m_phase == P_WAIT) begin
                  if (ls) begin
                     m_phase = P_STABLE; m_lock_run = 0;
                  end
               end else if (!ls) begin
                  m_phase = P_WAIT;
               end else begin
                  m_lock_run++;
                  if (m_lock_run == STAB) m_phase = P_READY;
               end
            end
            P_READY: begin
               if (!ls) begin
                  if (m_losses < 255) m_losses++;
                  m_retries = 0; m_phase = P_HOLD; m_hold_elapsed = 0;
               end
            end
            default: ;
         endcase
      end
   endtask

   initial begin
      model_reset();
      forever begin
         @(posedge refclk or negedge rst_n);
         if (!rst_n) model_reset();
         else        model_step(relock_req, pll_locked);
      end
   end

   // Compare process: outputs are stable at the falling edge.
   initial begin
      forever begin
         @(negedge refclk);
         check("m_pll_rst",   32'(pll_rst),       32'((m_phase == P_HOLD) || (m_phase == P_FAULT)));
         check("m_clk_ready", 32'(clk_ready),     32'(m_phase == P_READY));
         check("m_fault",     32'(fault),         32'(m_phase == P_FAULT));
         check("m_retry_cnt", 32'(retry_cnt),     32'(m_retries));
         check("m_lost_cnt",  32'(lock_lost_cnt), 32'(m_losses));
      end
   end

   // ---------------------------------------------------------------------------
   // Stimulus helpers
   // ---------------------------------------------------------------------------
   function automatic logic [7:0] out_val(input int which);
      case (which)
         W_PLL_RST: return {7'd0, pll_rst};
         W_READY:   return {7'd0, clk_ready};
         W_FAULT:   return {7'd0, fault};
         W_RETRY:   return {4'd0, retry_cnt};
         default:   return lock_lost_cnt;
      endcase
   endfunction

   task automatic next_drive();
      @(negedge refclk);
      #1;
   endtask

   // Counts rising edges until the selected output equals val, bounded.
   task automatic wait_for(input string name, input int which, input logic [7:0] val,
                           input int budget, output int n);
      n = 0;
      while (out_val(which) !== val && n < budget) begin
         @(posedge refclk);
         #1;
         n++;
      end
      if (out_val(which) !== val) check({"wait_", name}, 32'(out_val(which)), 32'(val));
   endtask

   task automatic reach_ready();
      int n;
      wait_for("rst_fall", W_PLL_RST, 8'd0, 40, n);
      repeat ($urandom_range(0, 5)) @(posedge refclk);
      next_drive();
      pll_locked = 1'b1;
      wait_for("ready", W_READY, 8'd1, 40, n);
   endtask

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   // ---------------------------------------------------------------------------
   // Scenarios
   // ---------------------------------------------------------------------------
   initial begin
      int n;
      int run_left;

      // Reset values while rst_n is held low.
      repeat (3) @(negedge refclk);
      check("rst_pll_rst",   32'(pll_rst),       32'd1);
      check("rst_clk_ready", 32'(clk_ready),     32'd0);
      check("rst_fault",     32'(fault),         32'd0);
      check("rst_retry",     32'(retry_cnt),     32'd0);
      check("rst_lost",      32'(lock_lost_cnt), 32'd0);

      // Power-up: PLL reset held exactly HOLD edges, lock 10 cycles later.
      #1 rst_n = 1'b1;
      wait_for("pwr_rst_fall", W_PLL_RST, 8'd0, 20, n);
      check("pwr_hold_edges", n, HOLD);
      repeat (9) @(posedge refclk);
      next_drive();
      pll_locked = 1'b1;
      wait_for("pwr_ready", W_READY, 8'd1, 40, n);
      check("pwr_ready_edges", n, 11);
      check("pwr_retry", 32'(retry_cnt), 32'd0);

      // Lock loss in READY: 3 edges to clk_ready fall / pll_rst rise.
      next_drive();
      pll_locked = 1'b0;
      wait_for("loss_ready_fall", W_READY, 8'd0, 10, n);
      check("loss_edges",   n, 3);
      check("loss_pll_rst", 32'(pll_rst),       32'd1);
      check("loss_lost",    32'(lock_lost_cnt), 32'd1);
      wait_for("loss_rst_fall", W_PLL_RST, 8'd0, 20, n);
      check("loss_hold_edges", n, HOLD);

      // One-cycle glitch after 5 cycles in STABLE.
      next_drive();
      pll_locked = 1'b1;
      repeat (8) @(negedge refclk);
      #1 pll_locked = 1'b0;
      next_drive();
      pll_locked = 1'b1;
      wait_for("glitch_ready", W_READY, 8'd1, 40, n);
      check("glitch_ready_edges", n, 11);
      check("glitch_retry", 32'(retry_cnt), 32'd0);

      // relock_req on the very edge that would register a lock loss.
      next_drive();
      pll_locked = 1'b0;
      next_drive();
      next_drive();
      relock_req = 1'b1;
      @(posedge refclk);
      #1;
      check("relock_loss_ready",   32'(clk_ready),     32'd0);
      check("relock_loss_pll_rst", 32'(pll_rst),       32'd1);
      check("relock_loss_lost",    32'(lock_lost_cnt), 32'd1);
      next_drive();
      relock_req = 1'b0;

      // No lock at all: three timed-out attempts, then FAULT.
      wait_for("fault_rise", W_FAULT, 8'd1, 300, n);
      check("fault_edges",   n, 3 * (HOLD + TMO));
      check("fault_retry",   32'(retry_cnt), 32'd2);
      check("fault_pll_rst", 32'(pll_rst),   32'd1);
      repeat (20) begin
         next_drive();
         pll_locked = 1'($urandom_range(0, 1));
      end
      next_drive();
      pll_locked = 1'b0;
      relock_req = 1'b1;
      @(posedge refclk);
      #1;
      check("fault_exit_fault",   32'(fault),     32'd0);
      check("fault_exit_pll_rst", 32'(pll_rst),   32'd1);
      check("fault_exit_retry",   32'(retry_cnt), 32'd0);
      next_drive();
      relock_req = 1'b0;

      // 300 lock losses: counter saturates.
      for (int i = 0; i < 300; i++) begin
         reach_ready();
         next_drive();
         pll_locked = 1'b0;
         wait_for("sat_ready_fall", W_READY, 8'd0, 10, n);
      end
      check("sat_lost", 32'(lock_lost_cnt), 32'd255);

      // Asynchronous reset while in STABLE.
      wait_for("ar_rst_fall", W_PLL_RST, 8'd0, 20, n);
      next_drive();
      pll_locked = 1'b1;
      repeat (5) @(posedge refclk);
      next_drive();
      rst_n = 1'b0;
      #1;
      check("ar_pll_rst",   32'(pll_rst),       32'd1);
      check("ar_clk_ready", 32'(clk_ready),     32'd0);
      check("ar_fault",     32'(fault),         32'd0);
      check("ar_retry",     32'(retry_cnt),     32'd0);
      check("ar_lost",      32'(lock_lost_cnt), 32'd0);
      next_drive();
      rst_n = 1'b1;
      wait_for("ar_rst_fall2", W_PLL_RST, 8'd0, 20, n);
      check("ar_hold_edges", n, HOLD);
      wait_for("ar_ready", W_READY, 8'd1, 40, n);
      check("ar_ready_edges", n, 9);

      // Randomized phase: lock held for random runs, occasional relock_req.
      run_left = 0;
      for (int i = 0; i < 1500; i++) begin
         next_drive();
         if (run_left == 0) begin
            pll_locked = ($urandom_range(0, 99) < 70);
            run_left   = $urandom_range(1, 40);
         end
         run_left--;
         relock_req = ($urandom_range(0, 199) == 0);
      end
      next_drive();
      relock_req = 1'b0;
      repeat (3) @(negedge refclk);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule : tb_pll_lock_sequencer
